// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: default bus widths and the arbiter state encoding.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_WR_ISSUE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM arbiter: display reads win unless a write has been starved,
// one command outstanding at a time, with a read-data timeout.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = SDRAM_ADDR_W,
    parameter int DATA_W     = SDRAM_DATA_W,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              sdram_clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest,
    output logic              busy
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic              rd_gnt_q, rd_gnt_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic              busy_q, busy_d;
    logic              wr_pending;

    // wr_gnt is registered, so during its pulse the loader still holds the
    // request it just had accepted; masking it avoids issuing that write twice.
    assign wr_pending = wr_req && !wr_gnt_q;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        to_d       = to_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        m_read_d   = 1'b0;
        m_write_d  = 1'b0;
        rd_gnt_d   = 1'b0;
        wr_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!wr_pending) begin
                    starve_d = '0;
                end
                if (rd_req && (!wr_pending || starve_q < SC_W'(STARVE_MAX))) begin
                    state_d  = ST_RD_ISSUE;
                    addr_d   = rd_addr;
                    m_read_d = 1'b1;
                end else if (wr_pending) begin
                    state_d   = ST_WR_ISSUE;
                    addr_d    = wr_addr;
                    wdata_d   = wr_data;
                    m_write_d = 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                if (!m_waitrequest) begin
                    state_d  = ST_RD_WAIT;
                    rd_gnt_d = 1'b1;
                    to_d     = '0;
                    if (wr_req && starve_q != SC_W'(STARVE_MAX)) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end else begin
                    m_read_d = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (m_readdatavalid) begin
                    state_d    = ST_IDLE;
                    rd_data_d  = m_readdata;
                    rd_valid_d = 1'b1;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    rd_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_WR_ISSUE: begin
                if (!m_waitrequest) begin
                    state_d  = ST_IDLE;
                    wr_gnt_d = 1'b1;
                    starve_d = '0;
                end else begin
                    m_write_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            to_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            m_read_q   <= 1'b0;
            m_write_q  <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            to_q       <= to_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            m_read_q   <= m_read_d;
            m_write_q  <= m_write_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_gnt      = rd_gnt_q;
    assign wr_gnt      = wr_gnt_q;
    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;
    assign m_address   = addr_q;
    assign m_writedata = wdata_q;
    assign m_read      = m_read_q;
    assign m_write     = m_write_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level memory and arbitration model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 8;
    localparam int TIMEOUT    = 255;

    logic              sdram_clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic              m_waitrequest;
    logic              busy;

    always #5 sdram_clk = ~sdram_clk;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .sdram_clk(sdram_clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // SDRAM responder state
    logic [DATA_W-1:0] sd_mem [16];
    int  cfg_wait, cfg_lat;
    bit  cfg_rand, cfg_noresp;
    bit  cmd_seen;
    int  wait_left, lat_left;
    bit  resp_pend;
    logic [DATA_W-1:0] resp_data;

    // monitor state
    int  cyc;
    int  rd_gnt_cnt, wr_gnt_cnt, rd_valid_cnt, rd_err_cnt, both_cnt;
    int  m_read_cyc, m_write_cyc, wr_unstable;
    bit  auto_drop;
    bit  acc_rd_ev, acc_wr_ev;
    logic [ADDR_W-1:0] acc_addr, wr_first_addr;
    logic [DATA_W-1:0] acc_wdata, wr_first_data;
    bit  grant_log [$];

    task automatic clear_mon();
        rd_gnt_cnt = 0; wr_gnt_cnt = 0; rd_valid_cnt = 0; rd_err_cnt = 0; both_cnt = 0;
        m_read_cyc = 0; m_write_cyc = 0; wr_unstable = 0;
        grant_log.delete();
    endtask

    // One clock: note what the DUT issues at this edge, then emulate the SDRAM
    // and record the outputs that appear after the edge.
    task automatic cycle();
        bit acc_rd, acc_wr;
        acc_rd    = m_read && !m_waitrequest;
        acc_wr    = m_write && !m_waitrequest;
        acc_addr  = m_address;
        acc_wdata = m_writedata;
        acc_rd_ev = acc_rd;
        acc_wr_ev = acc_wr;
        if (acc_wr) sd_mem[m_address[3:0]] = m_writedata;
        @(posedge sdram_clk);
        #1;
        cyc++;
        m_readdatavalid = 1'b0;
        m_readdata      = DATA_W'($urandom);
        if (acc_rd && !cfg_noresp) begin
            resp_pend = 1'b1;
            lat_left  = cfg_rand ? int'($urandom_range(4, 1)) : cfg_lat;
            resp_data = sd_mem[acc_addr[3:0]];
        end
        if (resp_pend) begin
            lat_left--;
            if (lat_left <= 0) begin
                m_readdatavalid = 1'b1;
                m_readdata      = resp_data;
                resp_pend       = 1'b0;
            end
        end
        if (m_read || m_write) begin
            if (!cmd_seen) begin
                cmd_seen  = 1'b1;
                wait_left = cfg_rand ? int'($urandom_range(3, 0)) : cfg_wait;
            end else if (wait_left > 0) begin
                wait_left--;
            end
            m_waitrequest = (wait_left != 0);
        end else begin
            cmd_seen      = 1'b0;
            m_waitrequest = 1'b0;
        end
        if (m_read && m_write) both_cnt++;
        if (m_read) m_read_cyc++;
        if (m_write) begin
            if (m_write_cyc == 0) begin
                wr_first_addr = m_address;
                wr_first_data = m_writedata;
            end else if (m_address !== wr_first_addr || m_writedata !== wr_first_data) begin
                wr_unstable++;
            end
            m_write_cyc++;
        end
        if (rd_gnt) begin rd_gnt_cnt++; grant_log.push_back(1'b0); end
        if (wr_gnt) begin wr_gnt_cnt++; grant_log.push_back(1'b1); end
        if (rd_valid) rd_valid_cnt++;
        if (rd_err) rd_err_cnt++;
        if (auto_drop) begin
            if (rd_gnt) rd_req = 1'b0;
            if (wr_gnt) wr_req = 1'b0;
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 400 && busy; i++) cycle();
        repeat (2) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        n_cmp++;
        if ({rd_gnt, wr_gnt, rd_valid, rd_err, m_read, m_write, busy} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {rd_gnt, wr_gnt, rd_valid, rd_err, m_read, m_write, busy});
        end
        n_cmp++;
        if (m_address !== '0 || m_writedata !== '0 || rd_data !== '0) begin
            n_bad++;
            $display("FAIL reset_buses: got addr=%h wdata=%h rdata=%h expected all 0",
                     m_address, m_writedata, rd_data);
        end
        rst = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_read();
        int c0, t_v, addr_bad;
        logic [DATA_W-1:0] got;
        clear_mon();
        sd_mem[0] = 16'h00F0;
        cfg_wait = 2; cfg_lat = 3; auto_drop = 1'b1;
        rd_addr = 25'h12C00; rd_req = 1'b1;
        c0 = cyc; t_v = -1; addr_bad = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (m_read && m_address !== 25'h12C00) addr_bad++;
            if (rd_valid && t_v < 0) begin t_v = cyc - c0; got = rd_data; end
        end
        n_cmp++;
        if (rd_gnt_cnt != 1 || rd_valid_cnt != 1) begin
            n_bad++;
            $display("FAIL single_read_pulses: got gnt=%0d valid=%0d expected 1/1", rd_gnt_cnt, rd_valid_cnt);
        end
        n_cmp++;
        if (got !== 16'h00F0) begin
            n_bad++;
            $display("FAIL single_read_data: got %h expected 00f0", got);
        end
        n_cmp++;
        if (m_read_cyc != 3 || addr_bad != 0) begin
            n_bad++;
            $display("FAIL single_read_cmd: got m_read cycles=%0d bad addr=%0d expected 3/0", m_read_cyc, addr_bad);
        end
        n_cmp++;
        if (t_v != 1 + (1 + cfg_wait) + cfg_lat) begin
            n_bad++;
            $display("FAIL single_read_latency: got %0d expected %0d", t_v, 1 + (1 + cfg_wait) + cfg_lat);
        end
        $display("read addr=%h data=%h latency=%0d", rd_addr, got, t_v);
    endtask

    task automatic test_simultaneous();
        clear_mon();
        cfg_wait = 0; cfg_lat = 1; auto_drop = 1'b1;
        rd_addr = 25'h00003; wr_addr = 25'h00009; wr_data = 16'h1234;
        rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 0; i < 50 && wr_gnt_cnt == 0; i++) cycle();
        settle();
        n_cmp++;
        if (grant_log.size() != 2 || grant_log[0] != 1'b0 || grant_log[1] != 1'b1) begin
            n_bad++;
            $display("FAIL simultaneous_order: got %0d grants first=%0d expected read then write",
                     grant_log.size(), grant_log.size() > 0 ? int'(grant_log[0]) : -1);
        end
        $display("simultaneous: %0d grants", grant_log.size());
    endtask

    task automatic test_starvation();
        clear_mon();
        cfg_wait = 0; cfg_lat = 1; auto_drop = 1'b0;
        rd_addr = 25'h00001; wr_addr = 25'h00002; wr_data = 16'hBEEF;
        rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 0; i < 400 && grant_log.size() < 27; i++) cycle();
        rd_req = 1'b0; wr_req = 1'b0;
        settle();
        n_cmp++;
        if (grant_log.size() < 27) begin
            n_bad++;
            $display("FAIL starve_count: got %0d grants expected >= 27", grant_log.size());
        end
        for (int i = 0; i < 27 && i < grant_log.size(); i++) begin
            n_cmp++;
            if (grant_log[i] != ((i % (STARVE_MAX + 1)) == STARVE_MAX)) begin
                n_bad++;
                $display("FAIL starve_pattern[%0d]: got %0d expected %0d", i,
                         grant_log[i], (i % (STARVE_MAX + 1)) == STARVE_MAX);
            end
        end
        $display("starvation: %0d grants, %0d writes", grant_log.size(), wr_gnt_cnt);
    endtask

    task automatic test_write_stable();
        clear_mon();
        cfg_wait = 4; auto_drop = 1'b1;
        wr_addr = 25'h00005; wr_data = 16'hFFFF; wr_req = 1'b1;
        for (int i = 0; i < 30 && wr_gnt_cnt == 0; i++) cycle();
        settle();
        n_cmp++;
        if (m_write_cyc != 5 || wr_unstable != 0) begin
            n_bad++;
            $display("FAIL write_hold: got cycles=%0d changes=%0d expected 5/0", m_write_cyc, wr_unstable);
        end
        n_cmp++;
        if (wr_first_addr !== 25'h00005 || wr_first_data !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL write_bus: got addr=%h data=%h expected 0000005/ffff", wr_first_addr, wr_first_data);
        end
        n_cmp++;
        if (wr_gnt_cnt != 1 || m_read_cyc != 0) begin
            n_bad++;
            $display("FAIL write_gnt: got wr_gnt=%0d m_read cycles=%0d expected 1/0", wr_gnt_cnt, m_read_cyc);
        end
        $display("write addr=%h data=%h held=%0d", wr_first_addr, wr_first_data, m_write_cyc);
    endtask

    task automatic test_timeout();
        int t_g, t_e;
        bit err_busy;
        clear_mon();
        cfg_wait = 0; cfg_noresp = 1'b1; auto_drop = 1'b1;
        rd_addr = ADDR_W'($urandom); rd_req = 1'b1;
        t_g = -1; t_e = -1; err_busy = 1'b1;
        for (int i = 0; i < 400 && t_e < 0; i++) begin
            cycle();
            if (rd_gnt) t_g = cyc;
            if (rd_err) begin t_e = cyc; err_busy = busy; end
        end
        n_cmp++;
        if (t_e < 0 || t_e - t_g != TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d expected %0d", t_e < 0 ? -1 : t_e - t_g, TIMEOUT);
        end
        n_cmp++;
        if (err_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_busy: got %b expected 0", err_busy);
        end
        m_readdatavalid = 1'b1;
        repeat (4) cycle();
        n_cmp++;
        if (rd_valid_cnt != 0 || rd_err_cnt != 1) begin
            n_bad++;
            $display("FAIL timeout_pulses: got valid=%0d err=%0d expected 0/1", rd_valid_cnt, rd_err_cnt);
        end
        cfg_noresp = 1'b0;
        $display("timeout: rd_err after %0d cycles", t_e - t_g);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] ref_mem [16];
        logic [DATA_W-1:0] exp_q [$];
        int consec, n_rd, n_wr;
        clear_mon();
        cfg_rand = 1'b1; auto_drop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sd_mem[i]  = DATA_W'($urandom);
            ref_mem[i] = sd_mem[i];
        end
        consec = 0; n_rd = 0; n_wr = 0;
        for (int i = 0; i < 2500; i++) begin
            cycle();
            if (rd_gnt) begin
                n_cmp++;
                if (!acc_rd_ev || acc_addr !== rd_addr) begin
                    n_bad++;
                    $display("FAIL rand_rd_addr: got %h expected %h", acc_addr, rd_addr);
                end
                exp_q.push_back(ref_mem[rd_addr[3:0]]);
                if (wr_req) consec++;
                n_cmp++;
                if (consec > STARVE_MAX) begin
                    n_bad++;
                    $display("FAIL rand_starve: got %0d reads while write waits expected <= %0d", consec, STARVE_MAX);
                end
                rd_req = 1'b0;
            end
            if (wr_gnt) begin
                n_cmp++;
                if (!acc_wr_ev || acc_addr !== wr_addr || acc_wdata !== wr_data) begin
                    n_bad++;
                    $display("FAIL rand_wr_cmd: got %h/%h expected %h/%h", acc_addr, acc_wdata, wr_addr, wr_data);
                end
                ref_mem[wr_addr[3:0]] = wr_data;
                n_wr++;
                $display("write addr=%h data=%h", wr_addr, wr_data);
                consec = 0;
                wr_req = 1'b0;
            end
            if (!wr_req) consec = 0;
            if (rd_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_rd_extra: got data %h expected no rd_valid", rd_data);
                end else if (rd_data !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL rand_rd_data: got %h expected %h", rd_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                n_rd++;
                $display("read data=%h", rd_data);
            end
            if (rd_err) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_rd_err: got rd_err expected none");
            end
            if (i < 2300) begin
                if (!rd_req && $urandom_range(1, 0) == 1) begin
                    rd_req = 1'b1; rd_addr = ADDR_W'($urandom);
                end
                if (!wr_req && $urandom_range(2, 0) == 0) begin
                    wr_req = 1'b1; wr_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom);
                end
            end
        end
        settle();
        n_cmp++;
        if (exp_q.size() != 0 || n_rd == 0 || n_wr == 0) begin
            n_bad++;
            $display("FAIL rand_drain: got pending=%0d reads=%0d writes=%0d expected 0/>0/>0", exp_q.size(), n_rd, n_wr);
        end
        n_cmp++;
        if (both_cnt != 0) begin
            n_bad++;
            $display("FAIL rand_exclusive: got %0d cycles with m_read and m_write expected 0", both_cnt);
        end
        cfg_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        cfg_wait = 0; cfg_lat = 6; auto_drop = 1'b1;
        rd_addr = 25'h00007; rd_req = 1'b1;
        for (int i = 0; i < 20 && rd_gnt_cnt == 0; i++) cycle();
        rst = 1'b1;
        cycle();
        n_cmp++;
        if ({rd_gnt, wr_gnt, rd_valid, rd_err, m_read, m_write, busy} !== 7'b0) begin
            n_bad++;
            $display("FAIL midreset_flags: got %b expected 0000000",
                     {rd_gnt, wr_gnt, rd_valid, rd_err, m_read, m_write, busy});
        end
        n_cmp++;
        if (m_address !== '0 || m_writedata !== '0 || rd_data !== '0) begin
            n_bad++;
            $display("FAIL midreset_buses: got addr=%h wdata=%h rdata=%h expected all 0",
                     m_address, m_writedata, rd_data);
        end
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        n_cmp++;
        if (rd_valid_cnt != 0 || rd_gnt_cnt != 1 || rd_err_cnt != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_late: got valid=%0d gnt=%0d err=%0d busy=%b expected 0/1/0/0",
                     rd_valid_cnt, rd_gnt_cnt, rd_err_cnt, busy);
        end
        $display("reset mid-read: rd_valid count=%0d", rd_valid_cnt);
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        m_readdata = '0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
        cfg_wait = 0; cfg_lat = 1; cfg_rand = 1'b0; cfg_noresp = 1'b0;
        cmd_seen = 1'b0; wait_left = 0; lat_left = 0; resp_pend = 1'b0; resp_data = '0;
        cyc = 0; auto_drop = 1'b0;
        acc_addr = '0; acc_wdata = '0; wr_first_addr = '0; wr_first_data = '0;
        for (int i = 0; i < 16; i++) sd_mem[i] = DATA_W'(16'h1111 * i + 16'h0101);
        clear_mon();

        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_write_stable();
        test_timeout();
        test_random();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SDRAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, maximum consecutive read grants while a write waits.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for read data.
REQ-005 sdram_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rd_req  in  1  display-fetch read request; held with rd_addr until rd_gnt.
REQ-008 rd_addr  in  ADDR_W  read word address.
REQ-009 rd_gnt  out  1  one-cycle pulse: read command accepted by SDRAM.
REQ-010 rd_data  out  DATA_W  returned read word, valid with rd_valid.
REQ-011 rd_valid  out  1  one-cycle pulse: rd_data valid.
REQ-012 rd_err  out  1  one-cycle pulse: read timed out.
REQ-013 wr_req  in  1  frame-loader write request; held with wr_addr/wr_data until wr_gnt.
REQ-014 wr_addr  in  ADDR_W  write word address.
REQ-015 wr_data  in  DATA_W  write word.
REQ-016 wr_gnt  out  1  one-cycle pulse: write accepted by SDRAM.
REQ-017 m_address  out  ADDR_W, m_read  out  1, m_write  out  1, m_writedata  out  DATA_W: SDRAM master command.
REQ-018 m_readdata  in  DATA_W, m_readdatavalid  in  1, m_waitrequest  in  1: SDRAM master response.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE; one transaction outstanding at a time.
REQ-021 IDLE: rd_req and (!wr_req or starve_cnt < STARVE_MAX) -> RD_ISSUE; else wr_req -> WR_ISSUE; else stay.
REQ-022 Arbitration decision made in IDLE only; request changes during a transaction do not alter it.
REQ-023 RD_ISSUE: m_read=1, m_address=latched rd_addr; on m_waitrequest=0 pulse rd_gnt, go RD_WAIT.
REQ-024 RD_WAIT: m_read=0; on m_readdatavalid register m_readdata to rd_data, pulse rd_valid next cycle, go IDLE.
REQ-025 RD_WAIT timeout: TIMEOUT cycles without m_readdatavalid -> pulse rd_err, rd_valid stays 0, go IDLE.
REQ-026 m_readdatavalid outside RD_WAIT SHALL be ignored.
REQ-027 WR_ISSUE: m_write=1, m_address/m_writedata=latched wr_addr/wr_data; on m_waitrequest=0 pulse wr_gnt, go IDLE.
REQ-028 Address/data latched on IDLE exit; m_* stable while m_waitrequest=1.
REQ-029 starve_cnt: +1 per rd_gnt while wr_req=1, saturates at STARVE_MAX, clears on wr_gnt or when wr_req=0 in IDLE.
REQ-030 m_read and m_write never both 1; both 0 in IDLE and RD_WAIT.
REQ-031 Minimum read turnaround: IDLE->RD_ISSUE->RD_WAIT->IDLE = 3 cycles plus SDRAM latency.

Reset
REQ-032 rst SHALL force state IDLE, starve_cnt and timeout counter 0, all pulse outputs, m_read, m_write and busy 0, m_address, m_writedata and rd_data 0.
REQ-033 rst mid-transaction SHALL abort without any gnt/valid pulse; a late m_readdatavalid after reset is ignored.

Structure
REQ-034 State encoding and default ADDR_W/DATA_W SHALL live in shared package sdram_pkg, reused by vga_controller.
REQ-035 Timeout and starvation counters SHALL be inline; no sub-module required.

Verification
REQ-036 rd_req only, addr 0x12C00, waitrequest 2 cycles, data 0x00F0 after 3 -> one rd_gnt, rd_valid with rd_data=0x00F0.
REQ-037 rd_req and wr_req held continuously, zero wait -> exactly 8 reads then 1 write, repeating; starve_cnt clears after each write.
REQ-038 Simultaneous rd_req/wr_req with starve_cnt=0 -> read granted first, write next.
REQ-039 Read with no m_readdatavalid -> rd_err after 255 cycles in RD_WAIT, state IDLE, no rd_valid.
REQ-040 rst asserted in RD_WAIT, then readdatavalid -> no rd_valid, all outputs 0, busy 0.
REQ-041 Write addr 0x00005, data 0xFFFF, waitrequest 4 cycles -> m_write/address/data stable 5 cycles, single wr_gnt.
